pb_led_ctrl: RTL and testbench
==============================

# pb_led_ctrl

Parametrised push-button to LED controller for the XC9572XL breakout and later boards. It synchronises and debounces `CHANNELS` buttons. Each debounced press steps that channel's LED through OFF, ON and BLINK, and the block drives true and complemented LED outputs. It sits directly between the board's button pins and LED pins; no other logic is required.

## Interface

- `CHANNELS`, 2: number of independent button/LED channels, ≥1.
- `DB_CYCLES`, 50000: consecutive clock cycles a changed input must hold before it is accepted, ≥1.
- `BLINK_HALF`, 1000000: clock cycles per blink half-period, ≥2.
- `PB_ACTIVE_LOW`, 1: 1 means a pressed button reads 0 at the pin; 0 means a pressed button reads 1.

- `clk` input, 1 bit: single clock; all state is on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `pb` input, `CHANNELS` bits: raw button pins, asynchronous to `clk`.
- `led` output, `CHANNELS` bits: LED drive, 1 means lit.
- `led_n` output, `CHANNELS` bits: registered complement of `led`.
- `press` output, `CHANNELS` bits: one-cycle pulse per accepted press.

One clock; reset is asynchronous and active-low.

## Operation

Each channel is independent and identical.

- **Synchroniser:** two flops, reset to the inactive pin level. The output is normalised to active-high `pb_s`.
- **Debounce:** `db` (reset 0) and `cnt` (width `$clog2(DB_CYCLES)`, minimum 1, reset 0).
  - If `pb_s == db`, then `cnt <= 0`.
  - Otherwise, if `cnt == DB_CYCLES-1`, then `db <= pb_s` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt+1`.
  - Any return to `db` level before acceptance restarts the count.
- **Press:** `press` is registered. It is 1 for exactly the cycle in which `db` has just become 1. Release produces no pulse and no mode change.
- **Mode FSM:**
  - States are OFF=0, ON=1, BLINK=2. Reset state is OFF.
  - It advances on the same edge that sets `press`: OFF→ON→BLINK→OFF.
  - Encoding 3 is unreachable and recovers to OFF on the next edge.
- **Blink generator:** shared by all channels and free-running from reset.
  - `bcnt` counts 0..`BLINK_HALF-1`.
  - `ph` toggles on each wrap. Both reset to 0.
  - Entering BLINK does not restart the generator.
- **LED:** `led` and `led_n` are registered from the post-edge state, so there is no lag behind the FSM.
  - `led = (state==ON) | (state==BLINK & ph)`.
  - `led_n = ~led`.

## Timing

- **Reset values:** `led`=0, `led_n`=all 1, `press`=0, state OFF, `db`=0, all counters 0, `ph`=0.
- **Press latency:**
  - A pin change first sampled at edge k sets `db`, `press`, state and `led` at edge k+1+`DB_CYCLES`.
  - That is `DB_CYCLES`+2 edges inclusive of k.
  - `press` falls at the next edge.
- **Glitch rejection:** a pulse of ≤`DB_CYCLES`-1 synchronised cycles is ignored.
- **Blink:** `ph` toggles every `BLINK_HALF` cycles, so the full period is 2×`BLINK_HALF`.
- **Simultaneous presses:** presses on several channels in the same cycle each pulse and advance independently.
- **Reset mid-operation:** all state clears immediately without waiting for a clock. A button held through reset release is seen as a new press `DB_CYCLES`+2 edges after the first post-reset edge.
- **Counter arithmetic:** counters never exceed their terminal value, and all compares are unsigned.

## Configuration

- `PB_LED_BLINK_EN` defined:
  - The FSM uses three states as above.
  - The blink generator is present.
- `PB_LED_BLINK_EN` undefined:
  - State is 1 bit, and each press toggles OFF↔ON.
  - `BLINK_HALF` is ignored, and the blink counter is not instantiated.
  - `led` = state.

## Test plan

All scenarios use `CHANNELS`=2, `DB_CYCLES`=4, `BLINK_HALF`=3, `PB_ACTIVE_LOW`=1.

1. Hold `rst_n`=0 with `pb`=2'b11, then release → `led`=00, `led_n`=11 and `press`=00 throughout, with no pulses for 20 cycles.
2. `pb[0]`=0 from edge k for 10 cycles → `press[0]`=1 for one cycle after edge k+5. At that edge `led[0]`=1 and `led_n[0]`=0. Channel 1 stays unchanged.
3. `pb[0]` low for 3 cycles, high, repeated 5 times → no `press[0]` and `led[0]` constant.
4. Second press → `led[0]` toggles every 3 cycles in step with `ph`. Third press → `led[0]`=0. With the macro undefined, the second press gives `led[0]`=0.
5. `pb`=2'b00 on the same edge → `press`=2'b11 in the same cycle, and both LEDs step together.
6. Assert `rst_n`=0 mid-debounce with `cnt`=2 while holding `pb[1]`=0 → outputs clear without a clock edge. After release, `press[1]` pulses 6 edges later.

Source files
------------

// File: rtl/pb_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pb_led_ctrl
// Purpose  : Push-button to LED controller. Every channel synchronises and
//            debounces one button pin. Each accepted press advances that
//            channel's LED mode. The LED is driven as true and complemented
//            registered outputs.
//            Optional feature macro: PB_LED_BLINK_EN
//              defined   -> modes OFF -> ON -> BLINK -> OFF, using a shared
//                           blink generator
//              undefined -> 1-bit mode, each press toggles OFF <-> ON
// Ports    : clk    - single clock, rising edge
//            rst_n  - asynchronous active-low reset
//            pb     - [CHANNELS] raw button pins (asynchronous)
//            led    - [CHANNELS] LED drive, 1 = lit
//            led_n  - [CHANNELS] registered complement of led
//            press  - [CHANNELS] one-cycle pulse per accepted press
// Revision : 1.0 - initial release
// ============================================================================
module pb_led_ctrl #(
    parameter int CHANNELS      = 2,
    parameter int DB_CYCLES     = 50000,
    parameter int BLINK_HALF    = 1000000,
    parameter int PB_ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] pb,
    output logic [CHANNELS-1:0] led,
    output logic [CHANNELS-1:0] led_n,
    output logic [CHANNELS-1:0] press
);

    // Debounce counter width. It is never narrower than 1 bit.
    localparam int                c_db_w    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DB_CYCLES - 1);
    // Pin level of a released button. The synchronisers reset to this level.
    localparam logic              c_pin_idle = (PB_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    // Reject illegal parameter sets at elaboration time.
    if (CHANNELS < 1 || DB_CYCLES < 1 || BLINK_HALF < 2) begin : g_bad_params
        $error("pb_led_ctrl: illegal parameter value");
    end

`ifdef PB_LED_BLINK_EN
    localparam int c_st_w = 2;
    localparam logic [c_st_w-1:0] c_st_off   = 2'd0;
    localparam logic [c_st_w-1:0] c_st_on    = 2'd1;
    localparam logic [c_st_w-1:0] c_st_blink = 2'd2;

    localparam int                c_bl_w    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [c_bl_w-1:0] c_bl_last = c_bl_w'(BLINK_HALF - 1);

    // The blink generator is shared and free-running. Entering BLINK never
    // restarts it, so all blinking channels stay in phase.
    logic [c_bl_w-1:0] r_bcnt;
    logic              r_ph;
    logic              w_bwrap;
    logic              w_ph_next;

    assign w_bwrap   = (r_bcnt == c_bl_last);
    // The LED registers take the post-edge phase so that they do not lag.
    assign w_ph_next = r_ph ^ w_bwrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
            r_ph   <= 1'b0;
        end else begin
            r_bcnt <= w_bwrap ? '0 : r_bcnt + 1'b1;
            r_ph   <= w_ph_next;
        end
    end
`else
    localparam int c_st_w = 1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic              r_sync1;
        logic              r_sync2;
        logic              r_db;
        logic [c_db_w-1:0] r_cnt;
        logic              r_press;
        logic              r_led;
        logic              r_led_n;
        logic [c_st_w-1:0] r_state;
        logic [c_st_w-1:0] w_state_next;
        logic              w_led_next;
        logic              w_pb_s;
        logic              w_accept;
        logic              w_rise;

        // Normalise so that 1 means pressed, whatever the pin polarity.
        assign w_pb_s   = (PB_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
        // A differing level that has held for DB_CYCLES edges is accepted on
        // this edge.
        assign w_accept = (w_pb_s != r_db) && (r_cnt == c_db_last);
        // Only the rising side of the debounced level counts as a press.
        assign w_rise   = w_accept & w_pb_s;

        always_comb begin
            w_state_next = r_state;
            w_led_next   = 1'b0;
`ifdef PB_LED_BLINK_EN
            case (r_state)
                c_st_off:   if (w_rise) w_state_next = c_st_on;
                c_st_on:    if (w_rise) w_state_next = c_st_blink;
                c_st_blink: if (w_rise) w_state_next = c_st_off;
                default:    w_state_next = c_st_off;
            endcase
            w_led_next = (w_state_next == c_st_on) ||
                         ((w_state_next == c_st_blink) && w_ph_next);
`else
            if (w_rise) w_state_next = ~r_state;
            w_led_next = w_state_next[0];
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= c_pin_idle;
                r_sync2 <= c_pin_idle;
                r_db    <= 1'b0;
                r_cnt   <= '0;
                r_press <= 1'b0;
                r_state <= '0;
                r_led   <= 1'b0;
                r_led_n <= 1'b1;
            end else begin
                r_sync1 <= pb[i];
                r_sync2 <= r_sync1;
                if (w_pb_s == r_db) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_db  <= w_pb_s;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_press <= w_rise;
                r_state <= w_state_next;
                r_led   <= w_led_next;
                r_led_n <= ~w_led_next;
            end
        end

        assign led[i]   = r_led;
        assign led_n[i] = r_led_n;
        assign press[i] = r_press;
    end

endmodule
`default_nettype wire

// File: tb/tb_pb_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pb_led_ctrl
// Purpose  : Directed, self-checking bench for pb_led_ctrl with
//            CHANNELS=2, DB_CYCLES=4, BLINK_HALF=3, PB_ACTIVE_LOW=1.
//            The expected values follow whichever build of PB_LED_BLINK_EN
//            is compiled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pb_led_ctrl;

`ifdef PB_LED_BLINK_EN
    localparam bit c_blink = 1'b1;
`else
    localparam bit c_blink = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] pb;
    logic [1:0] led;
    logic [1:0] led_n;
    logic [1:0] press;

    int n_cmp  = 0;
    int n_fail = 0;
    int ecount;

    pb_led_ctrl #(
        .CHANNELS     (2),
        .DB_CYCLES    (4),
        .BLINK_HALF   (3),
        .PB_ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pb   (pb),
        .led  (led),
        .led_n(led_n),
        .press(press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count edges since reset release. The blink phase after edge n is
    // (n / BLINK_HALF) mod 2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    function automatic logic ph_model();
        return logic'((ecount / 3) % 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset with buttons released
        rst_n = 1'b0;
        pb    = 2'b11;
        repeat (3) tick();
        check("rst_led",   led,   2'b00);
        check("rst_led_n", led_n, 2'b11);
        check("rst_press", press, 2'b00);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_press", press, 2'b00);
            check("idle_led",   led,   2'b00);
        end

        // 2: first press on channel 0, pressed 6 edges after it is driven
        pb = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("p1_wait_press", press, 2'b00);
        end
        tick();
        check("p1_press", press, 2'b01);
        check("p1_led",   led,   2'b01);
        check("p1_led_n", led_n, 2'b10);
        tick();
        check("p1_press_fall", press, 2'b00);
        check("p1_led_hold",   led,   2'b01);
        repeat (3) tick();
        pb = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("release_press", press, 2'b00);
        end
        check("release_led", led, 2'b01);

        // 3: three-cycle glitches are rejected
        for (int r = 0; r < 5; r++) begin
            pb = 2'b10;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("glitch_press", press, 2'b00);
            end
            pb = 2'b11;
            for (int i = 0; i < 3; i++) begin
                tick();
                check("glitch_press", press, 2'b00);
            end
        end
        check("glitch_led", led, 2'b01);
        repeat (4) tick();

        // 4: the second press gives BLINK, or OFF in the toggle build
        pb = 2'b10;
        repeat (5) tick();
        tick();
        check("p2_press", press, 2'b01);
        check("p2_led0",  {1'b0, led[0]}, {1'b0, c_blink ? ph_model() : 1'b0});
        for (int i = 0; i < 6; i++) begin
            tick();
            check("p2_blink", {1'b0, led[0]}, {1'b0, c_blink ? ph_model() : 1'b0});
        end
        pb = 2'b11;
        repeat (8) tick();
        // The third press gives OFF, or ON again in the toggle build
        pb = 2'b10;
        repeat (5) tick();
        tick();
        check("p3_press", press, 2'b01);
        check("p3_led",   led,   {1'b0, ~c_blink});
        pb = 2'b11;
        repeat (8) tick();

        // 5: simultaneous presses on both channels
        pb = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sim_wait_press", press, 2'b00);
        end
        tick();
        check("sim_press", press, 2'b11);
        check("sim_led",   led,   {1'b1, c_blink});
        check("sim_led_n", led_n, {1'b0, ~c_blink});
        tick();
        check("sim_press_fall", press, 2'b00);
        pb = 2'b11;
        repeat (8) tick();

        // 6: asynchronous reset mid-debounce with channel 1 held down
        pb = 2'b01;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("arst_led",   led,   2'b00);
        check("arst_led_n", led_n, 2'b11);
        check("arst_press", press, 2'b00);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_wait", press, 2'b00);
        end
        tick();
        check("post_rst_press", press, 2'b10);
        check("post_rst_led",   led,   2'b10);
        tick();
        check("post_rst_fall",  press, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
